div_sched: RTL and testbench

Job-level controller for the stochastic divider datapath. It accepts one binary division job (dividend and divisor probabilities plus a stream length) and generates the two input bitstreams from on-chip LFSRs. It sequences an internal saturating-counter divider through a warm-up phase and then a measured phase, counting the quotient ones. The count is returned over a valid/ready handshake, so software and the top-level testbench get a deterministic, reproducible binary result per job.

---
 rtl/div_sched_pkg.sv | 24 ++
 rtl/sng_lfsr.sv | 32 +++
 rtl/div_sched.sv | 134 +++++++++++++
 tb/tb_div_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the stochastic divider job controller.
package div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int LFSR_W = 6;

    // Seeds sit roughly a third of the period apart on the same m-sequence,
    // which keeps the A, B and C streams decorrelated.
    localparam logic [LFSR_W-1:0] SEED_A   = 6'd1;
    localparam logic [LFSR_W-1:0] SEED_B   = 6'd58;
    localparam logic [LFSR_W-1:0] SEED_C   = 6'd59;

    // x^6 + x^5 + 1
    localparam logic [LFSR_W-1:0] TAP_MASK = 6'b110000;

    localparam logic [LFSR_W-1:0] CNT_INIT = LFSR_W'(1) << (LFSR_W - 1);

endpackage

// File: rtl/sng_lfsr.sv
// Stochastic number generator: Fibonacci LFSR plus a comparator against a
// probability numerator.
module sng_lfsr #(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(0)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_prob,
    output logic [WIDTH-1:0] o_rand,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    assign w_fb   = ^(r_state & TAPS);
    assign o_rand = r_state;
    assign o_bit  = (r_state < i_prob);

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[WIDTH-2:0], w_fb};
        end
    end

endmodule

// File: rtl/div_sched.sv
// Job controller for the stochastic divider: warm-up, measured run and a
// valid/ready result handshake around a saturating-counter divider.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int LEN_W  = 10,
    parameter int WARMUP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend_prob,
    input  logic [WIDTH-1:0] divisor_prob,
    input  logic [LEN_W-1:0] stream_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] quotient_cnt,
    output logic             busy
);

    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int PH_W   = (LEN_W > WARM_W) ? LEN_W : WARM_W;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_dvd_prob, r_dvs_prob, r_cnt, w_cnt_next;
    logic [WIDTH-1:0] w_c_rand, w_a_rand_unused, w_b_rand_unused;
    logic [LEN_W-1:0] r_len, r_qcnt;
    logic [PH_W-1:0]  r_left;
    logic             w_accept, w_en, w_a_bit, w_b_bit, w_q_bit, w_dec;
    logic             w_c_bit_unused;

    assign w_accept     = in_valid && (r_state == ST_IDLE);
    assign w_en         = (r_state == ST_WARM) || (r_state == ST_RUN);
    assign w_q_bit      = (r_cnt >= w_c_rand);
    assign w_dec        = w_q_bit && w_b_bit;
    assign quotient_cnt = r_qcnt;

    sng_lfsr #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_A)), .TAPS(WIDTH'(TAP_MASK))) u_lfsr_a (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_en(w_en),
        .i_prob(r_dvd_prob), .o_rand(w_a_rand_unused), .o_bit(w_a_bit)
    );

    sng_lfsr #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_B)), .TAPS(WIDTH'(TAP_MASK))) u_lfsr_b (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_en(w_en),
        .i_prob(r_dvs_prob), .o_rand(w_b_rand_unused), .o_bit(w_b_bit)
    );

    sng_lfsr #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_C)), .TAPS(WIDTH'(TAP_MASK))) u_lfsr_c (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_en(w_en),
        .i_prob('0), .o_rand(w_c_rand), .o_bit(w_c_bit_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A zero-length phase is skipped entirely rather than spending a cycle in it.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (WARMUP > 0)              w_next = ST_WARM;
                    else if (stream_len == '0)   w_next = ST_DONE;
                    else                         w_next = ST_RUN;
                end
            end
            ST_WARM: begin
                busy = 1'b1;
                if (r_left == '0) begin
                    w_next = (r_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_left == '0) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Saturating up/down counter; simultaneous inc and dec cancel.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_a_bit && !w_dec && (r_cnt != '1)) begin
            w_cnt_next = r_cnt + WIDTH'(1);
        end else if (w_dec && !w_a_bit && (r_cnt != '0)) begin
            w_cnt_next = r_cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dvd_prob <= dividend_prob;
            r_dvs_prob <= divisor_prob;
            r_len      <= stream_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= WIDTH'(CNT_INIT);
            r_qcnt <= '0;
            r_left <= '0;
        end else if (w_accept) begin
            r_cnt  <= WIDTH'(CNT_INIT);
            r_qcnt <= '0;
            if (WARMUP > 0) r_left <= PH_W'(WARMUP - 1);
            else            r_left <= PH_W'(stream_len - LEN_W'(1));
        end else if (r_state == ST_WARM) begin
            r_cnt  <= w_cnt_next;
            r_left <= (r_left == '0) ? PH_W'(r_len - LEN_W'(1)) : r_left - PH_W'(1);
        end else if (r_state == ST_RUN) begin
            r_cnt  <= w_cnt_next;
            r_qcnt <= r_qcnt + LEN_W'(w_q_bit);
            r_left <= r_left - PH_W'(1);
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Randomized self-checking bench for div_sched, run on three instances that
// differ only in WARMUP (16, 64, 0).
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int W  = 6;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          iv [3];
    logic          ir [3];
    logic          ov [3];
    logic          ordy [3];
    logic          bsy [3];
    logic [W-1:0]  dvd [3];
    logic [W-1:0]  dvs [3];
    logic [LW-1:0] len [3];
    logic [LW-1:0] qc [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div_sched #(
            .WIDTH(W), .LEN_W(LW), .WARMUP((g == 0) ? 16 : ((g == 1) ? 64 : 0))
        ) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .dividend_prob(dvd[g]), .divisor_prob(dvs[g]), .stream_len(len[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .quotient_cnt(qc[g]), .busy(bsy[g])
        );
    end

    function automatic int wu(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 64 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned s);
        return ((s << 1) & 63) | (((s >> 5) ^ (s >> 4)) & 1);
    endfunction

    // Reference: walks WARMUP+len cycles of the three random streams with
    // plain integer arithmetic for the saturating divider.
    function automatic int model(input int d, input int v, input int l, input int w);
        int unsigned a, b, c;
        int cnt, q, qb, inc, dec;
        a = SEED_A; b = SEED_B; c = SEED_C;
        cnt = 32; q = 0;
        for (int t = 0; t < w + l; t++) begin
            qb = (cnt >= int'(c)) ? 1 : 0;
            if (t >= w) q += qb;
            inc = (int'(a) < d) ? 1 : 0;
            dec = (qb == 1 && int'(b) < v) ? 1 : 0;
            cnt = cnt + inc - dec;
            if (cnt > 63) cnt = 63;
            if (cnt < 0) cnt = 0;
            a = lfsr_next(a); b = lfsr_next(b); c = lfsr_next(c);
        end
        return q;
    endfunction

    task automatic start_job(input int k, input int d, input int v, input int l);
        int guard;
        guard = 0;
        while (!ir[k] && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_job", 32'(ir[k]), 1);
        iv[k] = 1'b1; dvd[k] = W'(d); dvs[k] = W'(v); len[k] = LW'(l);
        @(negedge clk);
        iv[k] = 1'b0;
        dvd[k] = W'($urandom); dvs[k] = W'($urandom); len[k] = LW'($urandom);
    endtask

    task automatic run_job(input int k, input int d, input int v, input int l,
                           input int hold, output int cnt, output int lat);
        start_job(k, d, v, l);
        lat = 1;
        while (!ov[k] && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        cnt = int'(qc[k]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(ov[k]), 1);
            chk("hold_count", 32'(qc[k]), 32'(cnt));
            chk("hold_in_ready", 32'(ir[k]), 0);
        end
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        chk("in_ready_after_done", 32'(ir[k]), 1);
        chk("out_valid_after_done", 32'(ov[k]), 0);
    endtask

    initial begin
        int c, l, ca, cb, k, d, v, ln;
        real err_sum, avg;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; dvd[i] = '0; dvs[i] = '0; len[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_in_ready", 32'(ir[i]), 1);
            chk("reset_out_valid", 32'(ov[i]), 0);
            chk("reset_busy", 32'(bsy[i]), 0);
            chk("reset_count", 32'(qc[i]), 0);
        end

        run_job(0, 0, 0, 63, 0, c, l);
        chk("zero_probs_count", 32'(c), 32);
        chk("zero_probs_latency", 32'(l), 80);

        run_job(1, 40, 0, 100, 0, c, l);
        chk("saturated_count", 32'(c), 100);
        chk("saturated_latency", 32'(l), 165);

        run_job(2, 17, 9, 0, 5, c, l);
        chk("empty_count", 32'(c), 0);
        chk("empty_latency", 32'(l), 1);

        run_job(0, 30, 50, 200, 0, ca, l);
        chk("clean_job_count", 32'(ca), 32'(model(30, 50, 200, 16)));
        start_job(0, 30, 50, 200);
        repeat (16 + 50) @(negedge clk);
        chk("busy_mid_run", 32'(bsy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(ir[0]), 1);
        chk("abort_busy", 32'(bsy[0]), 0);
        chk("abort_out_valid", 32'(ov[0]), 0);
        run_job(0, 30, 50, 200, 0, cb, l);
        chk("rerun_after_abort", 32'(cb), 32'(ca));

        for (int i = 0; i < 1000; i++) begin
            k  = i % 3;
            d  = int'($urandom_range(63, 0));
            v  = int'($urandom_range(63, 0));
            ln = int'($urandom_range(23, 0));
            run_job(k, d, v, ln, int'($urandom_range(2, 0)), c, l);
            chk("random_count", 32'(c), 32'(model(d, v, ln, wu(k))));
            chk("random_latency", 32'(l), 32'(wu(k) + ln + 1));
        end

        err_sum = 0.0;
        for (int i = 0; i < 16; i++) begin
            v = int'($urandom_range(63, 32));
            d = int'($urandom_range(v, 8));
            run_job(1, d, v, 1000, 0, c, l);
            chk("ratio_job_count", 32'(c), 32'(model(d, v, 1000, 64)));
            err_sum = err_sum + real'(c) / 1000.0 - real'(d) / real'(v);
        end
        avg = err_sum / 16.0;
        chk("ratio_avg_within_4_64", 32'((avg <= 4.0 / 64.0 && avg >= -4.0 / 64.0) ? 1 : 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
